// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// clock_ctrl : seconds prescaler and RUN/SET_HRS/SET_MIN mode controller that
//              feeds the sec/min/hrs counter chain.            Rev 1.0
// ============================================================================
module clock_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned REPEAT_DLY = 25_000_000,
  parameter int unsigned REPEAT_PER = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       en_sec,
  output logic       adj_min,
  output logic       adj_hrs,
  output logic       zero_sec,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HRS = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PCNT_MAX  = WIDTH'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] BLINK_LIM = WIDTH'(TICK_DIV / 2);
  localparam logic [WIDTH-1:0] DLY_LIM   = WIDTH'(REPEAT_DLY - 1);
  localparam logic [WIDTH-1:0] PER_LIM   = WIDTH'(REPEAT_PER - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic mode_s1, mode_s2, mode_dly, mode_edge;
  logic inc_s1, inc_s2, inc_dly, inc_edge;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pcnt, pcnt_nx;
  logic [WIDTH-1:0] rcnt, rcnt_nx;
  logic             rpt_act, rpt_act_nx;
  logic             rpt_phase, rpt_phase_nx;
  logic             en_sec_nx, adj_min_nx, adj_hrs_nx, zero_sec_nx;
  logic             adj_nx, in_set, advance;

  // Button synchronizers and registered rising-edge detectors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_s1   <= 1'b0;
      mode_s2   <= 1'b0;
      mode_dly  <= 1'b0;
      mode_edge <= 1'b0;
      inc_s1    <= 1'b0;
      inc_s2    <= 1'b0;
      inc_dly   <= 1'b0;
      inc_edge  <= 1'b0;
    end else begin
      mode_s1   <= btn_mode;
      mode_s2   <= mode_s1;
      mode_dly  <= mode_s2;
      mode_edge <= mode_s2 & ~mode_dly;
      inc_s1    <= btn_inc;
      inc_s2    <= inc_s1;
      inc_dly   <= inc_s2;
      inc_edge  <= inc_s2 & ~inc_dly;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      pcnt      <= '0;
      rcnt      <= '0;
      rpt_act   <= 1'b0;
      rpt_phase <= 1'b0;
      en_sec    <= 1'b0;
      adj_min   <= 1'b0;
      adj_hrs   <= 1'b0;
      zero_sec  <= 1'b0;
    end else begin
      state     <= state_nx;
      pcnt      <= pcnt_nx;
      rcnt      <= rcnt_nx;
      rpt_act   <= rpt_act_nx;
      rpt_phase <= rpt_phase_nx;
      en_sec    <= en_sec_nx;
      adj_min   <= adj_min_nx;
      adj_hrs   <= adj_hrs_nx;
      zero_sec  <= zero_sec_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pcnt_nx      = pcnt;
    rcnt_nx      = rcnt;
    rpt_act_nx   = rpt_act;
    rpt_phase_nx = rpt_phase;
    en_sec_nx    = 1'b0;
    zero_sec_nx  = 1'b0;
    adj_nx       = 1'b0;
    in_set       = 1'b0;
    advance      = 1'b0;

    case (state)
      RUN: begin
        advance   = run_en;
        en_sec_nx = run_en && (pcnt == PCNT_MAX);
        if (mode_edge) begin
          state_nx = SET_HRS;
        end
      end
      SET_HRS: begin
        in_set  = 1'b1;
        advance = 1'b1;
        if (mode_edge) begin
          state_nx = SET_MIN;
        end
      end
      SET_MIN: begin
        in_set  = 1'b1;
        advance = 1'b1;
        if (mode_edge) begin
          state_nx    = RUN;
          zero_sec_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase

    if (advance) begin
      pcnt_nx = (pcnt == PCNT_MAX) ? '0 : pcnt + ONE;
    end
    // Entering or leaving the set session restarts the second from zero
    if ((state == RUN && state_nx == SET_HRS) || (state != RUN && state_nx == RUN)) begin
      pcnt_nx = '0;
    end

    // Mode edge takes priority: a coincident inc edge is dropped
    if (mode_edge || !in_set) begin
      rpt_act_nx   = 1'b0;
      rpt_phase_nx = 1'b0;
      rcnt_nx      = '0;
    end else if (inc_edge) begin
      adj_nx       = 1'b1;
      rpt_act_nx   = 1'b1;
      rpt_phase_nx = 1'b0;
      rcnt_nx      = '0;
    end else if (rpt_act && inc_s2) begin
      if (rcnt == (rpt_phase ? PER_LIM : DLY_LIM)) begin
        adj_nx       = 1'b1;
        rpt_phase_nx = 1'b1;
        rcnt_nx      = '0;
      end else begin
        rcnt_nx = rcnt + ONE;
      end
    end else begin
      rpt_act_nx   = 1'b0;
      rpt_phase_nx = 1'b0;
      rcnt_nx      = '0;
    end

    adj_hrs_nx = adj_nx && (state == SET_HRS);
    adj_min_nx = adj_nx && (state == SET_MIN);
  end

  assign mode  = state;
  assign blink = ((state == SET_HRS) || (state == SET_MIN)) && (pcnt < BLINK_LIM);

endmodule
`default_nettype wire

// File: tb/tb_clock_ctrl.sv
`default_nettype none
// Testbench for clock_ctrl: directed scenarios plus random button/run_en
// activity, every output compared each cycle against a rule-level model.
module tb_clock_ctrl;

  localparam int TD  = 10;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic       clk;
  logic       reset;
  logic       run_en;
  logic       btn_mode;
  logic       btn_inc;
  logic       en_sec;
  logic       adj_min;
  logic       adj_hrs;
  logic       zero_sec;
  logic [1:0] mode;
  logic       blink;

  clock_ctrl #(
    .WIDTH      (16),
    .TICK_DIV   (TD),
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_en   (run_en),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .en_sec   (en_sec),
    .adj_min  (adj_min),
    .adj_hrs  (adj_hrs),
    .zero_sec (zero_sec),
    .mode     (mode),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  int m_mode, m_pcnt, m_t;
  bit m_act;
  bit mh[5];
  bit ih[5];
  int e_en, e_hrs, e_min, e_zero;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pcnt = 0; m_t = 0; m_act = 1'b0;
    e_en = 0; e_hrs = 0; e_min = 0; e_zero = 0;
    for (int j = 0; j < 5; j++) begin
      mh[j] = 1'b0;
      ih[j] = 1'b0;
    end
  endtask

  // One rising clock edge of the reference behaviour; index 0 of the
  // histories holds the level sampled on this edge.
  task automatic model_edge();
    bit me, ie, held, pulse;
    for (int j = 4; j > 0; j--) begin
      mh[j] = mh[j-1];
      ih[j] = ih[j-1];
    end
    mh[0] = btn_mode;
    ih[0] = btn_inc;
    me    = mh[3] && !mh[4];
    ie    = ih[3] && !ih[4];
    held  = ih[2];
    pulse = 1'b0;

    e_en   = (m_mode == 0 && run_en && m_pcnt == TD - 1) ? 1 : 0;
    e_hrs  = 0;
    e_min  = 0;
    e_zero = 0;

    if (me) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (m_mode != 0 && ie) begin
      pulse = 1'b1;
      m_act = 1'b1;
      m_t   = 0;
    end else if (m_act && m_mode != 0 && held) begin
      m_t++;
      if (m_t >= DLY && ((m_t - DLY) % PER) == 0) pulse = 1'b1;
    end else begin
      m_act = 1'b0;
    end
    if (pulse) begin
      if (m_mode == 1) e_hrs = 1;
      else e_min = 1;
    end

    if (m_mode != 0 || run_en) m_pcnt = (m_pcnt + 1) % TD;
    if (me) begin
      if (m_mode == 2) e_zero = 1;
      if (m_mode != 1) m_pcnt = 0;
      m_mode = (m_mode + 1) % 3;
    end
  endtask

  task automatic compare_all();
    check_eq("en_sec",   int'(en_sec),   e_en);
    check_eq("adj_hrs",  int'(adj_hrs),  e_hrs);
    check_eq("adj_min",  int'(adj_min),  e_min);
    check_eq("zero_sec", int'(zero_sec), e_zero);
    check_eq("mode",     int'(mode),     m_mode);
    check_eq("blink",    int'(blink),    (m_mode != 0 && m_pcnt < TD / 2) ? 1 : 0);
  endtask

  // Called at a falling edge: drive, clock once, compare at the next falling edge
  task automatic step(input logic m, input logic i, input logic r);
    btn_mode = m;
    btn_inc  = i;
    run_en   = r;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic m, input logic i, input logic r, input int n);
    for (int k = 0; k < n; k++) step(m, i, r);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic mv, iv, rv;
    int   ml, il;

    reset    = 1'b0;
    run_en   = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compare_all();
    end
    reset = 1'b1;

    // Tick cadence, then a 4-cycle run_en gap
    hold(1'b0, 1'b0, 1'b1, 35);
    hold(1'b0, 1'b0, 1'b0, 4);
    hold(1'b0, 1'b0, 1'b1, 20);
    // Into SET_HRS, then a mode/inc collision into SET_MIN
    hold(1'b1, 1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 1'b1, 6);
    hold(1'b1, 1'b1, 1'b1, 4);
    hold(1'b0, 1'b0, 1'b1, 6);
    // Three single steps in SET_MIN
    for (int k = 0; k < 3; k++) begin
      hold(1'b0, 1'b1, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b1, 4);
    end
    // Back to RUN (zero_sec), then inc presses that must be ignored
    hold(1'b1, 1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 1'b1, 15);
    for (int k = 0; k < 3; k++) begin
      hold(1'b0, 1'b1, 1'b1, 3);
      hold(1'b0, 1'b0, 1'b1, 4);
    end
    // Auto-repeat in SET_HRS
    hold(1'b1, 1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 1'b1, 4);
    hold(1'b0, 1'b1, 1'b1, 40);
    hold(1'b0, 1'b0, 1'b1, 15);
    // Reset while in SET_MIN with inc held
    hold(1'b1, 1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 1'b1, 4);
    hold(1'b0, 1'b1, 1'b1, 10);
    reset_pulse();
    hold(1'b0, 1'b1, 1'b1, 10);
    hold(1'b0, 1'b0, 1'b1, 15);

    // Random activity
    mv = 1'b0; iv = 1'b0; ml = 5; il = 7;
    for (int c = 0; c < 3000; c++) begin
      if (ml == 0) begin
        mv = ~mv;
        ml = mv ? int'($urandom_range(3, 8)) : int'($urandom_range(3, 70));
      end else begin
        ml--;
      end
      if (il == 0) begin
        iv = ~iv;
        il = iv ? int'($urandom_range(2, 45)) : int'($urandom_range(2, 20));
      end else begin
        il--;
      end
      rv = ($urandom_range(0, 7) != 0);
      step(mv, iv, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_ctrl.md
# clock_ctrl

Run/set controller for the digital clock counter chain. It divides the system clock into a one-cycle seconds-enable pulse, and runs a mode state machine (RUN, SET_HRS, SET_MIN) driven by two push-buttons. In the set states it issues single-step adjust pulses for the minute and hour stages. It sits in front of the seconds/minutes/hours counter chain; the chain OR's `adj_min`/`adj_hrs` into the minute/hour stage enables and uses `zero_sec` as a synchronous clear of the seconds stage.

## Interface
- `WIDTH`, default 32: width of the prescaler and repeat counters.
- `TICK_DIV`, default 50_000_000: clk cycles per second tick; must be ≥ 2.
- `REPEAT_DLY`, default 25_000_000: cycles a held `btn_inc` waits after its first pulse before auto-repeat starts.
- `REPEAT_PER`, default 5_000_000: cycles between auto-repeat pulses; must be ≥ 1.
- `clk` in 1: system clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run_en` in 1: level; when low, the prescaler holds and no `en_sec` is issued.
- `btn_mode` in 1: asynchronous button level; each rising edge advances the mode.
- `btn_inc` in 1: asynchronous button level; steps the field being set.
- `en_sec` out 1: one-cycle pulse per second; drives the seconds-stage enable.
- `adj_min` out 1: one-cycle minute step pulse.
- `adj_hrs` out 1: one-cycle hour step pulse.
- `zero_sec` out 1: one-cycle pulse that clears seconds on exit from set mode.
- `mode` out 2: current state, encoded 0 = RUN, 1 = SET_HRS, 2 = SET_MIN.
- `blink` out 1: display blink for the field being set.

## Operation
- Each button goes through a 2-flop synchronizer, then a registered rising-edge detector. All sync, edge and delay flops reset to 0.
- Mode FSM transitions, each taken on a `btn_mode` edge:
  - RUN → SET_HRS
  - SET_HRS → SET_MIN
  - SET_MIN → RUN
- No other transitions exist. Encoding 3 is unreachable; if it is ever entered, the FSM goes to RUN on the next clk.
- Prescaler `pcnt` counts 0..TICK_DIV-1 and wraps to 0.
  - In RUN it advances only while `run_en` = 1.
  - In the set states it advances unconditionally; there it serves the blink only.
- `en_sec` = 1 for exactly one cycle when state = RUN, `run_en` = 1 and `pcnt` = TICK_DIV-1.
- `blink` = 1 when in a set state and `pcnt` < TICK_DIV/2 (integer division); 0 in RUN.
- Increment in SET_HRS: a `btn_inc` edge gives a one-cycle `adj_hrs` pulse.
- Increment in SET_MIN: a `btn_inc` edge gives a one-cycle `adj_min` pulse.
- `btn_inc` in RUN is ignored.
- Auto-repeat:
  - While synced `btn_inc` stays high in a set state, the repeat counter counts from the first pulse.
  - After REPEAT_DLY cycles, it emits one further pulse every REPEAT_PER cycles.
  - Release of the button, or any mode change, clears the repeat counter and stops repeats.
- SET_MIN → RUN: `zero_sec` pulses for one cycle and `pcnt` loads 0. The first `en_sec` after resuming comes TICK_DIV cycles later (with `run_en` = 1).
- Entry into SET_HRS from RUN: `pcnt` loads 0.
- Seconds do not advance in either set state.
- Simultaneous `btn_mode` and `btn_inc` edges: mode wins; the inc edge is discarded and produces no adjust pulse.
- `adj_min`, `adj_hrs`, `en_sec` and `zero_sec` are mutually exclusive in any cycle.

## Timing
- Reset values: `mode` = 0 (RUN), `pcnt` = 0, repeat counter = 0, and `en_sec`, `adj_min`, `adj_hrs`, `zero_sec`, `blink` all = 0.
- Assertion of `reset` mid-operation aborts any set session immediately. No `zero_sec` is issued.
- Button latency: an input rising before clk edge k updates `mode` at edge k+3.
  - The adjust pulse is high in the cycle following edge k+3.
  - `zero_sec` is high in the cycle following the edge on which `mode` becomes 0.
- `en_sec` period is exactly TICK_DIV cycles in steady RUN with `run_en` = 1.
- Deasserting `run_en` stretches the period by the number of low cycles, with no lost or extra tick.
- All outputs are registered, except `blink`, which is decoded from registered state.
- Throughput: at most one adjust pulse per cycle. Button edges closer than 2 cycles are not guaranteed to be resolved.

## Test plan
- **Tick**: TICK_DIV = 10, `run_en` = 1 from reset → `en_sec` pulses at cycles 10, 20, 30, each exactly one cycle wide. Dropping `run_en` low for 4 cycles shifts the next pulse by 4.
- **Mode cycle**: three `btn_mode` presses → `mode` goes 1, 2, 0, each 3 cycles after its press. `zero_sec` pulses once, on the 2 → 0 transition. The next `en_sec` comes 10 cycles after that transition.
- **Step**: in SET_MIN, 3 separate `btn_inc` presses → exactly 3 `adj_min` pulses and 0 `adj_hrs`. In RUN, the same presses → no pulses.
- **Auto-repeat**: REPEAT_DLY = 20, REPEAT_PER = 5, `btn_inc` held 40 cycles in SET_HRS → pulses at t0, t0+20, +25, +30, +35, then none after release.
- **Collision**: `btn_mode` and `btn_inc` rising in the same cycle in SET_HRS → `mode` becomes 2 and no `adj_hrs` pulse is issued.
- **Reset mid-set**: `reset` low while in SET_MIN with `btn_inc` held → immediately `mode` = 0 and all outputs 0. After release, no `zero_sec` and no adjust pulses occur.
